vga_timing_ctrl: RTL and testbench
==================================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 The block SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 The block SHALL have parameter HS_POL, default 0, asserted level of HSYNC.
REQ-010 The block SHALL have parameter VS_POL, default 0, asserted level of VSYNC.
REQ-011 The block SHALL have parameter RW/GW/BW, default 3/3/2, red/green/blue channel widths.
REQ-012 The block SHALL have parameter PIPE, default 1, range 0..4, framebuffer read latency in pixel ticks.
REQ-013 The block SHALL have parameter CNT_W, default 10, ROW/COLUMN width; H_TOTAL and V_TOTAL SHALL each be at most 2^CNT_W.
REQ-014 The block SHALL have ports: CLK in 1 clock; RST in 1 reset; PIX_EN in 1 pixel tick; RED in RW; GREEN in GW; BLUE in BW.
REQ-015 The block SHALL have ports: ROW out CNT_W; COLUMN out CNT_W; ROUT out RW; GOUT out GW; BOUT out BW.
REQ-016 The block SHALL have ports: HSYNC out 1; VSYNC out 1; ACTIVE out 1; VBLANK out 1; FRAME_START out 1.
REQ-017 The block SHALL use one clock, CLK, with RST synchronous and active-high.

Function
REQ-018 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP; line order SHALL be active, front porch, sync, back porch.
REQ-019 All state SHALL advance only on CLK edges with PIX_EN=1 (a "tick"); with PIX_EN=0 every register and output SHALL hold.
REQ-020 On each tick h_cnt SHALL increment and wrap from H_TOTAL-1 to 0; v_cnt SHALL increment only on that wrap, wrapping from V_TOTAL-1 to 0.
REQ-021 COLUMN SHALL equal h_cnt and ROW SHALL equal v_cnt as registered values, with no delay; they form the framebuffer read address.
REQ-022 Raw signals SHALL be derived from the counters: act = (h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE); hs = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vs = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
REQ-023 act, hs and vs SHALL pass through a PIPE-tick delay line, followed by one output register stage, so HSYNC, VSYNC and ACTIVE lag the counters by PIPE+1 ticks.
REQ-024 RED/GREEN/BLUE SHALL be sampled on the tick PIPE ticks after the corresponding ROW/COLUMN were presented.
REQ-025 ROUT/GOUT/BOUT SHALL take the sampled color when the delayed act=1 and SHALL be all zeros otherwise.
REQ-026 HSYNC SHALL equal HS_POL when the delayed hs=1 and ~HS_POL otherwise; VSYNC SHALL follow the same rule with VS_POL.
REQ-027 VBLANK SHALL be registered and high while v_cnt>=V_ACTIVE (undelayed), for use as a CPU interrupt source.
REQ-028 FRAME_START SHALL be high for exactly one CLK cycle: the cycle after the tick on which the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).
REQ-029 FRAME_START SHALL be cleared on the next CLK edge regardless of PIX_EN.
REQ-030 PIPE=0 SHALL be supported: color is sampled on the same tick that ROW/COLUMN are presented.

Reset
REQ-031 While RST=1 on a CLK edge, the block SHALL set h_cnt=0, v_cnt=0, ROW=0 and COLUMN=0, independent of PIX_EN.
REQ-032 Reset SHALL clear every delay-line stage to inactive, and SHALL set ROUT/GOUT/BOUT=0, ACTIVE=0, VBLANK=0 and FRAME_START=0.
REQ-033 Reset SHALL drive HSYNC=~HS_POL and VSYNC=~VS_POL.
REQ-034 Reset asserted mid-frame SHALL abandon the frame with no FRAME_START pulse; the first tick after release SHALL begin counting from (0,0).

Verification
REQ-035 Default parameters, PIX_EN=1: HSYNC SHALL be low for 96 ticks from h_cnt=656 (+2 ticks latency) in every 800-tick period; VSYNC SHALL be low on lines 490-491; a frame SHALL last 420000 ticks.
REQ-036 PIPE=2, with a bench model returning RED=COLUMN[2:0] two ticks late: ROUT SHALL equal the COLUMN[2:0] of the pixel with the same alignment as ACTIVE, and SHALL be 0 whenever ACTIVE=0.
REQ-037 PIX_EN high one cycle in four: all outputs SHALL hold between ticks, and the line period SHALL be 3200 CLK cycles.
REQ-038 H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, HS_POL=1: HSYNC SHALL be high exactly 2 of every 8 ticks, starting when h_cnt=5 is presented plus PIPE+1 ticks.
REQ-039 RST asserted for 1 cycle at h_cnt=300, v_cnt=200: the next cycle SHALL show ROW=COLUMN=0, HSYNC=VSYNC=1 and colors=0, with no FRAME_START pulse.
REQ-040 Three full frames: FRAME_START SHALL pulse exactly 3 times, each 1 CLK cycle wide, each immediately after the (H_TOTAL-1, V_TOTAL-1) tick.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel/line counters, a framebuffer-latency delay
// line that keeps sync, blanking and color aligned, and a frame-start strobe.
module vga_timing_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   RW       = 3,
  parameter int   GW       = 3,
  parameter int   BW       = 2,
  parameter int   PIPE     = 1,
  parameter int   CNT_W    = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PIX_EN,
  input  logic [RW-1:0]    RED,
  input  logic [GW-1:0]    GREEN,
  input  logic [BW-1:0]    BLUE,
  output logic [CNT_W-1:0] ROW,
  output logic [CNT_W-1:0] COLUMN,
  output logic [RW-1:0]    ROUT,
  output logic [GW-1:0]    GOUT,
  output logic [BW-1:0]    BOUT,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             ACTIVE,
  output logic             VBLANK,
  output logic             FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_LST = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_LST = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic             h_last, v_last;
  logic [2:0]       raw_flags, dly_flags;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);
  assign h_nxt  = h_last ? '0 : h_cnt + CNT_W'(1);
  assign v_nxt  = !h_last ? v_cnt : (v_last ? '0 : v_cnt + CNT_W'(1));

  // Flag order is {act, hs, vs}; all-zero means blanked and outside sync.
  assign raw_flags[2] = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign raw_flags[1] = (h_cnt >= H_SYNC_BEG) && (h_cnt <= H_SYNC_LST);
  assign raw_flags[0] = (v_cnt >= V_SYNC_BEG) && (v_cnt <= V_SYNC_LST);

  assign COLUMN = h_cnt;
  assign ROW    = v_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      VBLANK <= 1'b0;
    end else if (PIX_EN) begin
      h_cnt  <= h_nxt;
      v_cnt  <= v_nxt;
      VBLANK <= (v_nxt >= V_ACT_END);
    end
  end

  // The strobe is not gated by PIX_EN so it lasts exactly one CLK cycle.
  always_ff @(posedge CLK) begin
    if (RST) FRAME_START <= 1'b0;
    else     FRAME_START <= PIX_EN && h_last && v_last;
  end

  generate
    if (PIPE == 0) begin : g_nopipe
      assign dly_flags = raw_flags;
    end else begin : g_pipe
      logic [2:0] stage [PIPE];
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int i = 0; i < PIPE; i++) stage[i] <= 3'b000;
        end else if (PIX_EN) begin
          stage[0] <= raw_flags;
          for (int i = 1; i < PIPE; i++) stage[i] <= stage[i-1];
        end
      end
      assign dly_flags = stage[PIPE-1];
    end
  endgenerate

  // Color arriving now belongs to the pixel whose flags leave the delay line now.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ACTIVE <= 1'b0;
      HSYNC  <= ~HS_POL;
      VSYNC  <= ~VS_POL;
      ROUT   <= '0;
      GOUT   <= '0;
      BOUT   <= '0;
    end else if (PIX_EN) begin
      ACTIVE <= dly_flags[2];
      HSYNC  <= dly_flags[1] ? HS_POL : ~HS_POL;
      VSYNC  <= dly_flags[0] ? VS_POL : ~VS_POL;
      ROUT   <= dly_flags[2] ? RED   : '0;
      GOUT   <= dly_flags[2] ? GREEN : '0;
      BOUT   <= dly_flags[2] ? BLUE  : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a small 8x6 raster run through two instances
// (PIPE=2 with positive hsync, PIPE=0 with positive vsync) against a tick-count model.
module tb_vga_timing_ctrl;

  logic       CLK = 1'b0;
  logic       RST, PIX_EN;
  logic [2:0] red2, green2, red0, green0;
  logic [1:0] blue2, blue0;
  logic [3:0] row2, col2, row0, col0;
  logic [2:0] rout2, gout2, rout0, gout0;
  logic [1:0] bout2, bout0;
  logic       hsync2, vsync2, active2, vblank2, fs2;
  logic       hsync0, vsync0, active0, vblank0, fs0;

  int n = 0;
  int errCount = 0;
  int checkCount = 0;
  int fsCount = 0;
  int hsHigh = 0;
  bit tickSeen;

  always #5 CLK = ~CLK;

  vga_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .RW(3), .GW(3), .BW(2), .PIPE(2), .CNT_W(4)
  ) dut2 (
    .CLK(CLK), .RST(RST), .PIX_EN(PIX_EN),
    .RED(red2), .GREEN(green2), .BLUE(blue2),
    .ROW(row2), .COLUMN(col2), .ROUT(rout2), .GOUT(gout2), .BOUT(bout2),
    .HSYNC(hsync2), .VSYNC(vsync2), .ACTIVE(active2), .VBLANK(vblank2),
    .FRAME_START(fs2)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .RW(3), .GW(3), .BW(2), .PIPE(0), .CNT_W(4)
  ) dut0 (
    .CLK(CLK), .RST(RST), .PIX_EN(PIX_EN),
    .RED(red0), .GREEN(green0), .BLUE(blue0),
    .ROW(row0), .COLUMN(col0), .ROUT(rout0), .GOUT(gout0), .BOUT(bout0),
    .HSYNC(hsync0), .VSYNC(vsync0), .ACTIVE(active0), .VBLANK(vblank0),
    .FRAME_START(fs0)
  );

  // Raster position after m ticks: 8 pixels per line, 6 lines per frame.
  function automatic int hc(int m);
    return (m < 0) ? 0 : m % 8;
  endfunction

  function automatic int vc(int m);
    return (m < 0) ? 0 : (m / 8) % 6;
  endfunction

  function automatic bit fAct(int m);
    return (m >= 0) && (hc(m) < 4) && (vc(m) < 3);
  endfunction

  function automatic bit fHs(int m);
    return (m >= 0) && (hc(m) >= 5) && (hc(m) <= 6);
  endfunction

  function automatic bit fVs(int m);
    return (m >= 0) && (vc(m) == 4);
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s at tick %0d: got %0d, expected %0d", tag, n, actual, expected);
    end
  endtask

  task automatic checkAll();
    int m2, m0;
    bit expFs;
    m2 = n - 3;
    m0 = n - 1;
    expFs = tickSeen && (n > 0) && (n % 48 == 0);
    checkOutput("row2", int'(row2), vc(n));
    checkOutput("col2", int'(col2), hc(n));
    checkOutput("hsync2", int'(hsync2), fHs(m2) ? 1 : 0);
    checkOutput("vsync2", int'(vsync2), fVs(m2) ? 0 : 1);
    checkOutput("active2", int'(active2), int'(fAct(m2)));
    checkOutput("vblank2", int'(vblank2), (vc(n) >= 3) ? 1 : 0);
    checkOutput("fs2", int'(fs2), int'(expFs));
    checkOutput("rout2", int'(rout2), fAct(m2) ? hc(m2) % 8 : 0);
    checkOutput("gout2", int'(gout2), fAct(m2) ? vc(m2) % 8 : 0);
    checkOutput("bout2", int'(bout2), fAct(m2) ? (hc(m2) + vc(m2)) % 4 : 0);
    checkOutput("row0", int'(row0), vc(n));
    checkOutput("col0", int'(col0), hc(n));
    checkOutput("hsync0", int'(hsync0), fHs(m0) ? 0 : 1);
    checkOutput("vsync0", int'(vsync0), fVs(m0) ? 1 : 0);
    checkOutput("active0", int'(active0), int'(fAct(m0)));
    checkOutput("vblank0", int'(vblank0), (vc(n) >= 3) ? 1 : 0);
    checkOutput("fs0", int'(fs0), int'(expFs));
    checkOutput("rout0", int'(rout0), fAct(m0) ? 7 - hc(m0) : 0);
    checkOutput("gout0", int'(gout0), fAct(m0) ? (vc(m0) + 1) % 8 : 0);
    checkOutput("bout0", int'(bout0), fAct(m0) ? hc(m0) % 4 : 0);
  endtask

  // One CLK cycle: colors model a framebuffer with PIPE ticks of read latency.
  task automatic applyStimulus(input logic en, input logic rst);
    int m;
    PIX_EN = en;
    RST    = rst;
    m      = n - 2;
    red2   = 3'(hc(m));
    green2 = 3'(vc(m));
    blue2  = 2'(hc(m) + vc(m));
    red0   = 3'(7 - hc(n));
    green0 = 3'(vc(n) + 1);
    blue0  = 2'(hc(n));
    @(posedge CLK);
    tickSeen = en && !rst;
    if (rst) n = 0;
    else if (en) n++;
    #1;
    checkAll();
  endtask

  initial begin
    int guard;
    PIX_EN = 1'b0;
    RST    = 1'b1;
    red2 = '0; green2 = '0; blue2 = '0;
    red0 = '0; green0 = '0; blue0 = '0;

    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);

    // Three full frames at full rate, counting strobes and one line's sync pulse.
    for (int i = 0; i < 150; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (fs2) fsCount++;
      if (n >= 16 && n < 24 && hsync2) hsHigh++;
    end
    checkOutput("fs_count", fsCount, 3);
    checkOutput("hs_width", hsHigh, 2);

    // One tick in four: everything holds between ticks, a line takes 32 cycles.
    for (int i = 0; i < 96; i++) applyStimulus((i % 4) == 3, 1'b0);

    for (int i = 0; i < 100; i++) applyStimulus(1'($urandom_range(0, 1)), 1'b0);

    // Abandon a frame mid-line at (3,2) and restart from the origin.
    guard = 0;
    while (!(hc(n) == 3 && vc(n) == 2) && guard < 60) begin
      applyStimulus(1'b1, 1'b0);
      guard++;
    end
    checkOutput("reach_mid_frame", (hc(n) == 3 && vc(n) == 2) ? 1 : 0, 1);
    applyStimulus(1'b1, 1'b1);
    fsCount = 0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (fs2) fsCount++;
    end
    checkOutput("fs_after_reset", fsCount, 1);

    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
